shot_sequencer: RTL and testbench
=================================

SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 Parameter SHOTS, default 10, shots per game (1..15).
REQ-002 Parameter WDOG_MAX, default 63, cycles allowed in WAIT before abort.
REQ-003 Parameter LFSR_SEED, default 10'h2A5, target LFSR reset value (nonzero).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 fire  in  1  player fire button, level; a rising edge is the request.
REQ-007 new_game  in  1  level; restarts the game from IDLE or OVER.
REQ-008 xpos_set, rise_set, run_set  in  5 each  player shot parameters.
REQ-009 dir_set  in  1  initial direction: 0 = left, 1 = right.
REQ-010 result_valid, hit  in  1 each  completion and hit flag from the trajectory engine.
REQ-011 x_pos, rise_in, run_in  out  5 each  latched shot parameters to the engine.
REQ-012 direction_in  out  1  latched direction to the engine.
REQ-013 shoot  out  1  one-cycle shot request to the engine.
REQ-014 target_x, target_y  out  5 each  current target, LFSR bits [4:0] and [9:5].
REQ-015 calc_abort  out  1  one-cycle pulse on watchdog expiry; the top level ORs it into the engine reset.
REQ-016 score, shots_left  out  4 each  hits this game and shots remaining.
REQ-017 last_hit, busy, game_over  out  1 each  result of the last shot; state is not IDLE or OVER; state is OVER.

Function
REQ-018 States: IDLE, ISSUE, WAIT, SCORE, OVER; shoot SHALL be high only in ISSUE, calc_abort only on the WAIT->SCORE transition caused by the watchdog, game_over only in OVER.
REQ-019 fire SHALL be registered every cycle into fire_q; request = fire & ~fire_q.
REQ-020 IDLE->ISSUE SHALL occur when request=1 and rise_set!=0.
- A request with rise_set==0 is ignored; no parameters are latched.
REQ-021 On the IDLE->ISSUE edge the block SHALL latch x/rise/run/dir; the outputs SHALL hold the latched values until the next accepted request.
REQ-022 ISSUE->WAIT SHALL be unconditional after 1 cycle.
- Latency: shoot is high exactly the cycle after the fire edge is sampled.
REQ-023 WAIT clears the 6-bit watchdog on entry and increments it each cycle.
- WAIT->SCORE when result_valid=1; the hit input is captured that cycle.
- Otherwise WAIT->SCORE when the watchdog equals WDOG_MAX; the shot is captured as a miss and calc_abort pulses.
- If result_valid is high and the watchdog equals WDOG_MAX in the same cycle, result_valid SHALL win and calc_abort SHALL NOT pulse.
REQ-024 SCORE lasts 1 cycle:
- shots_left decrements; last_hit takes the captured hit.
- On a hit, score increments (saturating at 15) and the LFSR advances one step.
- SCORE->OVER if shots_left was 1, else SCORE->IDLE.
REQ-025 LFSR: 10-bit Fibonacci, taps x^10+x^7+1, shift left with feedback = bit9^bit6 into bit0; it SHALL advance only in SCORE on a hit.
REQ-026 result_valid outside WAIT SHALL be ignored; fire outside IDLE SHALL be ignored.
REQ-027 new_game in IDLE or OVER SHALL, on the next edge:
- set score=0, shots_left=SHOTS, last_hit=0 and state IDLE;
- leave the LFSR unchanged.
- new_game is ignored in ISSUE, WAIT and SCORE.
REQ-028 All arithmetic SHALL be unsigned 4-bit; shots_left SHALL never decrement below 0.

Reset
REQ-029 rst SHALL force, on the next clock edge:
- state=IDLE, fire_q=0, watchdog=0, LFSR=LFSR_SEED (target_x=5, target_y=21);
- latched params=0, score=0, shots_left=SHOTS, last_hit=0;
- shoot=0, calc_abort=0, busy=0, game_over=0.
REQ-030 rst asserted mid-shot SHALL abandon the shot with no score or shots_left change.
- Re-firing requires a fresh rising edge of fire after rst deasserts.

Structure
REQ-031 Shared package: state encoding, SHOTS/WDOG_MAX/LFSR_SEED defaults, LFSR tap constants.
REQ-032 All registers SHALL be built from the team's synchronous-reset flop module.
REQ-033 The LFSR SHALL be a separate sub-module, target_lfsr (ports: clk, rst, advance, value[9:0]).

Verification
REQ-034 Hit path.
- Stimulus: reset, xpos=10, rise=3, run=2, dir=1, then a fire edge; engine model returns result_valid=1 with hit=1 four cycles after shoot.
- Required: shoot is high for exactly 1 cycle with x_pos=10, rise_in=3, run_in=2, direction_in=1; then score=1, shots_left=9, last_hit=1, and the target moves off (5,21).
REQ-035 Zero rise and held fire.
- Stimulus: fire edge with rise_set=0; then fire held high for 20 cycles with rise_set=3.
- Required: no shoot for the rise=0 edge; exactly one shoot for the held fire.
REQ-036 Watchdog expiry.
- Stimulus: engine never returns result_valid.
- Required: calc_abort pulses once, 63 cycles after entering WAIT; last_hit=0, shots_left decrements, score unchanged.
REQ-037 Game end and restart.
- Stimulus: 10 missed shots, then an 11th fire edge, then new_game.
- Required: game_over=1 after the 10th shot; the 11th fire produces no shoot; new_game gives score=0, shots_left=10, game_over=0.
REQ-038 Collision and reset mid-shot.
- Stimulus: result_valid=1 (hit=1) in the same cycle the watchdog reaches 63; separately, rst asserted in WAIT.
- Required: the collision scores a hit with no calc_abort; the rst case restores all REQ-029 values.

Source files
------------

// File: rtl/shot_sequencer_pkg.sv
// Shared constants, state encoding and LFSR helper for the shot sequencer.
// Imported by the sequencer top and the target LFSR.
package shot_sequencer_pkg;

    localparam int         SHOTS_DEF     = 10;
    localparam int         WDOG_MAX_DEF  = 63;
    localparam logic [9:0] LFSR_SEED_DEF = 10'h2A5;

    // x^10 + x^7 + 1, shifting left with feedback into bit 0
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SCORE = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    typedef struct packed {
        logic [4:0] xpos;
        logic [4:0] rise;
        logic [4:0] run;
        logic       dir;
    } shot_params_t;

    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/sync_dff.sv
// Generic register with synchronous active-high reset and load enable.
// Every state element of the sequencer is built from this cell.
module sync_dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/target_lfsr.sv
// 10-bit Fibonacci LFSR holding the current target position.
// Steps once per cycle while advance is high.
module target_lfsr
    import shot_sequencer_pkg::*;
#(
    parameter logic [9:0] SEED = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [9:0] value
);

    logic [9:0] nxt;

    assign nxt = lfsr_next(value);

    sync_dff #(.W(10), .RST_VAL(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (advance),
        .d   (nxt),
        .q   (value)
    );

endmodule

// File: rtl/shot_sequencer.sv
// Game sequencer: accepts fire requests, hands shots to the trajectory
// engine, guards the wait with a watchdog and keeps score and targets.
module shot_sequencer
    import shot_sequencer_pkg::*;
#(
    parameter int         SHOTS     = SHOTS_DEF,
    parameter int         WDOG_MAX  = WDOG_MAX_DEF,
    parameter logic [9:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fire,
    input  logic       new_game,
    input  logic [4:0] xpos_set,
    input  logic [4:0] rise_set,
    input  logic [4:0] run_set,
    input  logic       dir_set,
    input  logic       result_valid,
    input  logic       hit,
    output logic [4:0] x_pos,
    output logic [4:0] rise_in,
    output logic [4:0] run_in,
    output logic       direction_in,
    output logic       shoot,
    output logic [4:0] target_x,
    output logic [4:0] target_y,
    output logic       calc_abort,
    output logic [3:0] score,
    output logic [3:0] shots_left,
    output logic       last_hit,
    output logic       busy,
    output logic       game_over
);

    localparam logic [3:0] SHOTS_INIT = 4'(SHOTS);
    localparam logic [5:0] WDOG_LIM   = 6'(WDOG_MAX);

    logic [2:0]   state_q, state_d;
    logic         fire_q;
    logic [5:0]   wdog_q, wdog_d;
    shot_params_t prm_q, prm_d;
    logic         hit_q, hit_d;
    logic [3:0]   score_q, score_d;
    logic [3:0]   left_q, left_d;
    logic         last_q, last_d;
    logic [9:0]   lfsr;
    logic         advance;

    logic in_idle, in_issue, in_wait, in_score, in_over;
    logic request, wdog_done;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_issue = (state_q == ST_ISSUE);
    assign in_wait  = (state_q == ST_WAIT);
    assign in_score = (state_q == ST_SCORE);
    assign in_over  = (state_q == ST_OVER);

    assign request   = fire & ~fire_q;
    assign wdog_done = (wdog_q == WDOG_LIM);

    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        prm_d   = prm_q;
        hit_d   = hit_q;
        score_d = score_q;
        left_d  = left_q;
        last_d  = last_q;
        advance = 1'b0;
        unique case (1'b1)
            in_idle: begin
                if (new_game) begin
                    score_d = 4'd0;
                    left_d  = SHOTS_INIT;
                    last_d  = 1'b0;
                end else if (request && (rise_set != 5'd0)) begin
                    prm_d.xpos = xpos_set;
                    prm_d.rise = rise_set;
                    prm_d.run  = run_set;
                    prm_d.dir  = dir_set;
                    state_d    = ST_ISSUE;
                end
            end
            in_issue: begin
                wdog_d  = 6'd0;
                state_d = ST_WAIT;
            end
            in_wait: begin
                // a result arriving on the expiry cycle still counts
                if (result_valid) begin
                    hit_d   = hit;
                    state_d = ST_SCORE;
                end else if (wdog_done) begin
                    hit_d   = 1'b0;
                    state_d = ST_SCORE;
                end else begin
                    wdog_d = wdog_q + 6'd1;
                end
            end
            in_score: begin
                left_d = (left_q != 4'd0) ? left_q - 4'd1 : 4'd0;
                last_d = hit_q;
                if (hit_q) begin
                    score_d = (score_q == 4'hF) ? 4'hF : score_q + 4'd1;
                    advance = 1'b1;
                end
                state_d = (left_q <= 4'd1) ? ST_OVER : ST_IDLE;
            end
            in_over: begin
                if (new_game) begin
                    score_d = 4'd0;
                    left_d  = SHOTS_INIT;
                    last_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sync_dff #(.W(3), .RST_VAL(ST_IDLE)) u_state (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (state_d),
        .q   (state_q)
    );

    sync_dff #(.W(1)) u_fire_q (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (fire),
        .q   (fire_q)
    );

    sync_dff #(.W(6)) u_wdog (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (wdog_d),
        .q   (wdog_q)
    );

    sync_dff #(.W($bits(shot_params_t))) u_prm (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (prm_d),
        .q   (prm_q)
    );

    sync_dff #(.W(1)) u_hit (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (hit_d),
        .q   (hit_q)
    );

    sync_dff #(.W(4)) u_score (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (score_d),
        .q   (score_q)
    );

    sync_dff #(.W(4), .RST_VAL(SHOTS_INIT)) u_left (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (left_d),
        .q   (left_q)
    );

    sync_dff #(.W(1)) u_last (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (last_d),
        .q   (last_q)
    );

    target_lfsr #(.SEED(LFSR_SEED)) u_target (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .value   (lfsr)
    );

    assign x_pos        = prm_q.xpos;
    assign rise_in      = prm_q.rise;
    assign run_in       = prm_q.run;
    assign direction_in = prm_q.dir;

    assign shoot      = in_issue;
    assign calc_abort = in_wait & ~result_valid & wdog_done;
    assign busy       = ~(in_idle | in_over);
    assign game_over  = in_over;

    assign target_x   = lfsr[4:0];
    assign target_y   = lfsr[9:5];
    assign score      = score_q;
    assign shots_left = left_q;
    assign last_hit   = last_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Self-checking bench for shot_sequencer with a game-level reference model.
// Stimulus mixes directed scenarios with randomized shots.
module tb_shot_sequencer;

    logic       clk = 1'b0;
    logic       rst, fire, new_game, dir_set, result_valid, hit;
    logic [4:0] xpos_set, rise_set, run_set;
    logic [4:0] x_pos, rise_in, run_in, target_x, target_y;
    logic       direction_in, shoot, calc_abort, last_hit, busy, game_over;
    logic [3:0] score, shots_left;

    int n_vec = 0;
    int n_err = 0;

    int         m_score;
    int         m_left;
    bit         m_last;
    logic [9:0] m_lfsr;

    always #5 clk = ~clk;

    shot_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .fire         (fire),
        .new_game     (new_game),
        .xpos_set     (xpos_set),
        .rise_set     (rise_set),
        .run_set      (run_set),
        .dir_set      (dir_set),
        .result_valid (result_valid),
        .hit          (hit),
        .x_pos        (x_pos),
        .rise_in      (rise_in),
        .run_in       (run_in),
        .direction_in (direction_in),
        .shoot        (shoot),
        .target_x     (target_x),
        .target_y     (target_y),
        .calc_abort   (calc_abort),
        .score        (score),
        .shots_left   (shots_left),
        .last_hit     (last_hit),
        .busy         (busy),
        .game_over    (game_over)
    );

    function automatic logic [9:0] ref_step(input logic [9:0] v);
        int fb;
        fb = ((int'(v) >> 9) ^ (int'(v) >> 6)) & 1;
        return 10'(((int'(v) << 1) | fb) & 'h3FF);
    endfunction

    task automatic model_new_game();
        m_score = 0;
        m_left  = 10;
        m_last  = 1'b0;
    endtask

    task automatic model_shot(input bit h);
        if (m_left > 0) m_left--;
        m_last = h;
        if (h) begin
            if (m_score < 15) m_score++;
            m_lfsr = ref_step(m_lfsr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fires one shot and plays the engine: result at shoot+lat (lat<0: never).
    task automatic run_shot(input logic [4:0] x, input logic [4:0] r,
                            input logic [4:0] n, input bit d,
                            input int hold, input int lat, input bit hv,
                            input int ng_at,
                            output int shoots, output int aborts,
                            output int abort_k, output logic [15:0] prm,
                            output bit timeout);
        xpos_set = x;
        rise_set = r;
        run_set  = n;
        dir_set  = d;
        fire     = 1'b1;
        shoots   = 0;
        aborts   = 0;
        abort_k  = -1;
        prm      = '0;
        timeout  = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 1) begin
                xpos_set = 5'($urandom);
                rise_set = 5'($urandom);
                run_set  = 5'($urandom);
                dir_set  = 1'($urandom);
            end
            fire         = (k < hold);
            new_game     = (k == ng_at);
            result_valid = (lat >= 0) && (k == 1 + lat);
            hit          = result_valid ? hv : 1'($urandom);
            #1;
            if (shoot) begin
                shoots++;
                prm = {x_pos, rise_in, run_in, direction_in};
            end
            if (calc_abort) begin
                aborts++;
                abort_k = k;
            end
            if (k > 1 && !busy && k >= hold) begin
                timeout = 1'b0;
                break;
            end
        end
        fire         = 1'b0;
        new_game     = 1'b0;
        result_valid = 1'b0;
        hit          = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_lfsr = 10'h2A5;
        model_new_game();
        n_vec++;
        if ({shoot, calc_abort, busy, game_over, last_hit} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000",
                     {shoot, calc_abort, busy, game_over, last_hit});
        end
        n_vec++;
        if (score !== 4'd0 || shots_left !== 4'd10) begin
            n_err++;
            $display("FAIL reset_counts: got score=%0d left=%0d want 0/10",
                     score, shots_left);
        end
        n_vec++;
        if (target_x !== 5'd5 || target_y !== 5'd21) begin
            n_err++;
            $display("FAIL reset_target: got (%0d,%0d) want (5,21)",
                     target_x, target_y);
        end
        n_vec++;
        if ({x_pos, rise_in, run_in, direction_in} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_params: got %h want 0000",
                     {x_pos, rise_in, run_in, direction_in});
        end
    endtask

    task automatic test_hit();
        int sh, ab, ak;
        logic [15:0] pr;
        bit to;
        run_shot(5'd10, 5'd3, 5'd2, 1'b1, 1, 4, 1'b1, -1, sh, ab, ak, pr, to);
        model_shot(1'b1);
        n_vec++;
        if (to || sh != 1 || ab != 0) begin
            n_err++;
            $display("FAIL hit_shoot: got shoots=%0d aborts=%0d to=%0b want 1/0/0",
                     sh, ab, to);
        end
        n_vec++;
        if (pr !== {5'd10, 5'd3, 5'd2, 1'b1}) begin
            n_err++;
            $display("FAIL hit_params: got %h want %h", pr,
                     {5'd10, 5'd3, 5'd2, 1'b1});
        end
        n_vec++;
        if (score !== 4'(m_score) || shots_left !== 4'(m_left) ||
            last_hit !== m_last) begin
            n_err++;
            $display("FAIL hit_score: got %0d/%0d/%0b want %0d/%0d/%0b",
                     score, shots_left, last_hit, m_score, m_left, m_last);
        end
        n_vec++;
        if ({target_y, target_x} !== m_lfsr ||
            {target_y, target_x} === 10'h2A5) begin
            n_err++;
            $display("FAIL hit_target: got %h want %h",
                     {target_y, target_x}, m_lfsr);
        end
        n_vec++;
        if ({x_pos, rise_in, run_in, direction_in} !== pr) begin
            n_err++;
            $display("FAIL hit_hold: got %h want %h",
                     {x_pos, rise_in, run_in, direction_in}, pr);
        end
    endtask

    task automatic test_zero_rise_hold();
        int sh, ab, ak, bad;
        logic [15:0] pr;
        bit to;
        xpos_set = 5'd20;
        rise_set = 5'd0;
        run_set  = 5'd7;
        dir_set  = 1'b0;
        fire     = 1'b1;
        bad      = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (shoot || busy) bad++;
        end
        fire = 1'b0;
        step();
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL zero_rise: got %0d busy cycles want 0", bad);
        end
        n_vec++;
        if ({x_pos, rise_in, run_in, direction_in} !==
            {5'd10, 5'd3, 5'd2, 1'b1}) begin
            n_err++;
            $display("FAIL zero_rise_latch: got %h want %h",
                     {x_pos, rise_in, run_in, direction_in},
                     {5'd10, 5'd3, 5'd2, 1'b1});
        end
        run_shot(5'd7, 5'd3, 5'd4, 1'b0, 20, 3, 1'b0, -1, sh, ab, ak, pr, to);
        model_shot(1'b0);
        n_vec++;
        if (to || sh != 1) begin
            n_err++;
            $display("FAIL held_fire: got shoots=%0d to=%0b want 1/0", sh, to);
        end
        n_vec++;
        if (shots_left !== 4'(m_left) || last_hit !== m_last) begin
            n_err++;
            $display("FAIL held_score: got %0d/%0b want %0d/%0b",
                     shots_left, last_hit, m_left, m_last);
        end
    endtask

    task automatic test_watchdog();
        int sh, ab, ak;
        logic [15:0] pr;
        bit to;
        run_shot(5'd1, 5'd5, 5'd1, 1'b0, 1, -1, 1'b1, 20, sh, ab, ak, pr, to);
        model_shot(1'b0);
        n_vec++;
        if (to || ab != 1 || ak != 65) begin
            n_err++;
            $display("FAIL wdog_abort: got aborts=%0d at=%0d want 1 at 65",
                     ab, ak);
        end
        n_vec++;
        if (score !== 4'(m_score) || shots_left !== 4'(m_left) ||
            last_hit !== 1'b0) begin
            n_err++;
            $display("FAIL wdog_score: got %0d/%0d/%0b want %0d/%0d/0",
                     score, shots_left, last_hit, m_score, m_left);
        end
    endtask

    task automatic test_collision();
        int sh, ab, ak;
        logic [15:0] pr;
        bit to;
        run_shot(5'd30, 5'd9, 5'd3, 1'b1, 1, 64, 1'b1, -1, sh, ab, ak, pr, to);
        model_shot(1'b1);
        n_vec++;
        if (to || ab != 0) begin
            n_err++;
            $display("FAIL collide_abort: got aborts=%0d want 0", ab);
        end
        n_vec++;
        if (score !== 4'(m_score) || last_hit !== 1'b1 ||
            {target_y, target_x} !== m_lfsr) begin
            n_err++;
            $display("FAIL collide_score: got %0d/%0b/%h want %0d/1/%h",
                     score, last_hit, {target_y, target_x}, m_score, m_lfsr);
        end
    endtask

    task automatic test_game_end();
        int sh, ab, ak, bad;
        logic [15:0] pr;
        bit to;
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_new_game();
        for (int i = 0; i < 10; i++) begin
            run_shot(5'($urandom), 5'($urandom_range(1, 31)), 5'($urandom),
                     1'($urandom), 1, $urandom_range(1, 10), 1'b0, -1,
                     sh, ab, ak, pr, to);
            model_shot(1'b0);
            n_vec++;
            if (to || shots_left !== 4'(m_left) ||
                game_over !== (m_left == 0)) begin
                n_err++;
                $display("FAIL game_shot%0d: got left=%0d over=%0b want %0d/%0b",
                         i, shots_left, game_over, m_left, m_left == 0);
            end
        end
        xpos_set = 5'd4;
        rise_set = 5'd4;
        fire     = 1'b1;
        bad      = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (shoot || !game_over) bad++;
        end
        fire = 1'b0;
        step();
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL over_fire: got %0d bad cycles want 0", bad);
        end
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_new_game();
        n_vec++;
        if (score !== 4'd0 || shots_left !== 4'd10 || game_over !== 1'b0 ||
            {target_y, target_x} !== m_lfsr) begin
            n_err++;
            $display("FAIL restart: got %0d/%0d/%0b/%h want 0/10/0/%h",
                     score, shots_left, game_over, {target_y, target_x}, m_lfsr);
        end
    endtask

    task automatic test_random();
        int sh, ab, ak, lat, sel;
        logic [15:0] pr, want_prm;
        logic [4:0] x, r, n;
        bit to, d, hv, exp_hit;
        for (int g = 0; g < 2; g++) begin
            while (m_left > 0) begin
                x = 5'($urandom);
                r = 5'($urandom_range(1, 31));
                n = 5'($urandom);
                d = 1'($urandom);
                hv = 1'($urandom);
                sel = $urandom_range(0, 9);
                lat = (sel == 0) ? -1 : (sel == 1) ? 64 :
                      (sel == 2) ? 0 : $urandom_range(1, 12);
                exp_hit = hv && lat >= 1 && lat <= 64;
                want_prm = {x, r, n, d};
                run_shot(x, r, n, d, 1, lat, hv, -1, sh, ab, ak, pr, to);
                model_shot(exp_hit);
                n_vec++;
                if (to || sh != 1 || pr !== want_prm) begin
                    n_err++;
                    $display("FAIL rnd_issue: got %0d/%h want 1/%h",
                             sh, pr, want_prm);
                end
                n_vec++;
                if ((lat >= 1 && lat <= 64) ? (ab != 0) : (ab != 1 || ak != 65)) begin
                    n_err++;
                    $display("FAIL rnd_abort: lat=%0d got aborts=%0d at %0d",
                             lat, ab, ak);
                end
                n_vec++;
                if (score !== 4'(m_score) || shots_left !== 4'(m_left) ||
                    last_hit !== m_last || {target_y, target_x} !== m_lfsr ||
                    game_over !== (m_left == 0)) begin
                    n_err++;
                    $display("FAIL rnd_state: got %0d/%0d/%0b/%h/%0b want %0d/%0d/%0b/%h/%0b",
                             score, shots_left, last_hit, {target_y, target_x},
                             game_over, m_score, m_left, m_last, m_lfsr,
                             m_left == 0);
                end
            end
            new_game = 1'b1;
            step();
            new_game = 1'b0;
            model_new_game();
        end
    endtask

    task automatic test_reset_mid_shot();
        int sh, ab, ak;
        logic [15:0] pr;
        bit to;
        run_shot(5'd12, 5'd6, 5'd1, 1'b1, 1, 2, 1'b1, -1, sh, ab, ak, pr, to);
        model_shot(1'b1);
        xpos_set = 5'd9;
        rise_set = 5'd2;
        fire     = 1'b1;
        step();
        fire = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_lfsr = 10'h2A5;
        model_new_game();
        n_vec++;
        if ({shoot, calc_abort, busy, game_over, last_hit} !== 5'b0 ||
            score !== 4'd0 || shots_left !== 4'd10) begin
            n_err++;
            $display("FAIL midrst_state: got %b %0d/%0d want 00000 0/10",
                     {shoot, calc_abort, busy, game_over, last_hit},
                     score, shots_left);
        end
        n_vec++;
        if (target_x !== 5'd5 || target_y !== 5'd21 ||
            {x_pos, rise_in, run_in, direction_in} !== 16'h0) begin
            n_err++;
            $display("FAIL midrst_regs: got (%0d,%0d) %h want (5,21) 0000",
                     target_x, target_y, {x_pos, rise_in, run_in, direction_in});
        end
        step();
        run_shot(5'd3, 5'd3, 5'd3, 1'b0, 1, 3, 1'b1, -1, sh, ab, ak, pr, to);
        model_shot(1'b1);
        n_vec++;
        if (to || sh != 1 || score !== 4'(m_score) ||
            shots_left !== 4'(m_left)) begin
            n_err++;
            $display("FAIL midrst_refire: got %0d %0d/%0d want 1 %0d/%0d",
                     sh, score, shots_left, m_score, m_left);
        end
    endtask

    initial begin
        rst          = 1'b1;
        fire         = 1'b0;
        new_game     = 1'b0;
        xpos_set     = 5'd0;
        rise_set     = 5'd0;
        run_set      = 5'd0;
        dir_set      = 1'b0;
        result_valid = 1'b0;
        hit          = 1'b0;
        test_reset();
        test_hit();
        test_zero_rise_hold();
        test_watchdog();
        test_collision();
        test_game_end();
        test_random();
        test_reset_mid_shot();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
